// File: rtl/im_loader.sv
// im_loader: fills the instruction memory from a byte stream while the CPU is held.
// Bytes arrive big-endian (first byte lands in [31:24]) and are written as 32-bit words
// to consecutive IM word indices starting at start_word. Runs never wrap past DEPTH-1.
module im_loader #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_word,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic [ADDR_W:0]   words_written_q, words_written_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic              err_q, err_d;

    // State and datapath registers; synchronous reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            remaining_q     <= '0;
            words_written_q <= '0;
            wdata_q         <= '0;
            byte_cnt_q      <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            remaining_q     <= remaining_d;
            words_written_q <= words_written_d;
            wdata_q         <= wdata_d;
            byte_cnt_q      <= byte_cnt_d;
            err_q           <= err_d;
        end
    end

    // Next-state logic: collect four bytes, write one word, repeat until count or IM end.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        remaining_d     = remaining_q;
        words_written_d = words_written_q;
        wdata_d         = wdata_q;
        byte_cnt_d      = byte_cnt_q;
        err_d           = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d          = start_word;
                    remaining_d     = word_count;
                    words_written_d = '0;
                    err_d           = 1'b0;
                    byte_cnt_d      = '0;
                    state_d         = (word_count == '0) ? S_FINISH : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (in_valid) begin
                    wdata_d    = {wdata_q[23:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                words_written_d = words_written_q + ONE_W;
                remaining_d     = remaining_q - ONE_W;
                if (remaining_q == ONE_W) begin
                    state_d = S_FINISH;
                end else if (addr_q == LAST_IDX) begin
                    // Request ran off the end of the IM: stop rather than wrap to 0.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_COLLECT;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore outputs; the write strobe is also masked by reset so no write escapes it.
    assign in_ready      = (state_q == S_COLLECT);
    assign im_we         = (state_q == S_WRITE) && !reset;
    assign im_addr       = addr_q;
    assign im_wdata      = wdata_q;
    assign busy          = (state_q != S_IDLE);
    assign cpu_hold      = busy;
    assign done          = (state_q == S_FINISH);
    assign err_overflow  = err_q;
    assign words_written = words_written_q;

endmodule
